// File: rtl/config_chain_loader.sv
// Config chain loader: serialises parallel config words LSB-first onto the tile
// config chain and returns the displaced bits as parallel readback words.
module config_chain_loader #(
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned CHAIN_LENGTH = 36
) (
    input  logic                  config_clock,
    input  logic                  config_nreset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  chain_in,
    output logic                  chain_enable,
    input  logic                  chain_out
);

    localparam int unsigned NW     = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned LB     = CHAIN_LENGTH - (NW - 1) * WORD_WIDTH;
    localparam int unsigned BIT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int unsigned WCNT_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [WORD_WIDTH-1:0] wshift, wshift_n;
    logic [WORD_WIDTH-1:0] rshift, rshift_n;
    logic [WORD_WIDTH-1:0] rdata_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [WCNT_W-1:0]     word_cnt, word_cnt_n;
    logic                  busy_n, done_n, wready_n, rvalid_n, chain_enable_n;

    logic                  last_word_c;
    logic                  word_end_c;
    logic                  rd_block_c;
    logic [WORD_WIDTH-1:0] captured_c;

    // The outgoing bit is always the LSB of the write shifter.
    assign chain_in = wshift[0];

    // Word position decode and the readback word including this cycle's captured bit.
    always_comb begin
        last_word_c         = (word_cnt == WCNT_W'(NW - 1));
        word_end_c          = (bit_cnt == (last_word_c ? BIT_W'(LB - 1) : BIT_W'(WORD_WIDTH - 1)));
        rd_block_c          = rvalid && !rready;
        captured_c          = rshift;
        captured_c[bit_cnt] = chain_out;
    end

    // Next-state and next-output logic; chain_enable for the coming cycle is decided here.
    always_comb begin
        state_n        = state;
        wshift_n       = wshift;
        rshift_n       = rshift;
        rdata_n        = rdata;
        bit_cnt_n      = bit_cnt;
        word_cnt_n     = word_cnt;
        rvalid_n       = rvalid && !rready;
        chain_enable_n = 1'b0;
        done_n         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (wvalid && wready) begin
                    state_n        = SHIFT;
                    wshift_n       = wdata;
                    // First shift of a word opens a new readback word: hold it while rdata is unread.
                    chain_enable_n = !rd_block_c;
                end
            end
            SHIFT: begin
                if (chain_enable) begin
                    if (word_end_c) begin
                        rdata_n   = captured_c;
                        rvalid_n  = 1'b1;
                        rshift_n  = '0;
                        wshift_n  = '0;
                        bit_cnt_n = '0;
                        if (last_word_c) begin
                            state_n    = DRAIN;
                            word_cnt_n = '0;
                        end else begin
                            state_n    = FETCH;
                            word_cnt_n = word_cnt + WCNT_W'(1);
                        end
                    end else begin
                        rshift_n       = captured_c;
                        wshift_n       = wshift >> 1;
                        bit_cnt_n      = bit_cnt + BIT_W'(1);
                        chain_enable_n = 1'b1;
                    end
                end else begin
                    chain_enable_n = !rd_block_c;
                end
            end
            DRAIN: begin
                if (rvalid && rready) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        wready_n = (state_n == FETCH);
        busy_n   = (state_n == FETCH) || (state_n == SHIFT) || (state_n == DRAIN);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) begin
            state        <= IDLE;
            wshift       <= '0;
            rshift       <= '0;
            rdata        <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wready       <= 1'b0;
            rvalid       <= 1'b0;
            chain_enable <= 1'b0;
        end else begin
            state        <= state_n;
            wshift       <= wshift_n;
            rshift       <= rshift_n;
            rdata        <= rdata_n;
            bit_cnt      <= bit_cnt_n;
            word_cnt     <= word_cnt_n;
            busy         <= busy_n;
            done         <= done_n;
            wready       <= wready_n;
            rvalid       <= rvalid_n;
            chain_enable <= chain_enable_n;
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: emulates a 36-bit tile config chain and checks
// readback against a frame-level model (readback = previous frame, last word masked).
module tb_config_chain_loader;

    localparam int unsigned WW        = 8;
    localparam int unsigned CL        = 36;
    localparam int unsigned NW        = 5;
    localparam logic [7:0]  LAST_MASK = 8'h0F;
    localparam int          BOUND     = 3000;

    typedef struct packed {
        logic [4:0][7:0] w;
        logic [4:0][7:0] exp_r;
        logic [7:0]      gap;
        logic [7:0]      hold;
        logic            spam;
        logic            rnd;
        logic [7:0]      exp_cyc;
    } vec_t;

    logic          config_clock;
    logic          config_nreset;
    logic          start;
    logic          busy;
    logic          done;
    logic [WW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [WW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          chain_in;
    logic          chain_enable;
    logic          chain_out;

    logic [CL-1:0]   chain_q;
    logic [4:0][7:0] model_prev;
    vec_t            vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    config_chain_loader #(
        .WORD_WIDTH  (WW),
        .CHAIN_LENGTH(CL)
    ) dut (
        .config_clock (config_clock),
        .config_nreset(config_nreset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .wdata        (wdata),
        .wvalid       (wvalid),
        .wready       (wready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .chain_in     (chain_in),
        .chain_enable (chain_enable),
        .chain_out    (chain_out)
    );

    initial config_clock = 1'b0;
    always #5 config_clock = ~config_clock;

    // Stand-in for the daisy-chained tile config registers.
    always @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) chain_q <= '0;
        else if (chain_enable) chain_q <= {chain_q[CL-2:0], chain_in};
    end
    assign chain_out = chain_q[CL-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},         32'(busy),         32'd0);
        check({tag, " done"},         32'(done),         32'd0);
        check({tag, " wready"},       32'(wready),       32'd0);
        check({tag, " rvalid"},       32'(rvalid),       32'd0);
        check({tag, " chain_enable"}, 32'(chain_enable), 32'd0);
        check({tag, " chain_in"},     32'(chain_in),     32'd0);
        check({tag, " rdata"},        32'(rdata),        32'd0);
    endtask

    task automatic model_update(input logic [4:0][7:0] w);
        model_prev    = w;
        model_prev[4] = w[4] & LAST_MASK;
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int         wi = 0, ri = 0, en = 0, dn = 0, cyc = 0;
        int         gap_left = 0, hold_left = 0, gap_en = 0, hold_en = 0;
        int         unstable = 0, busy_bad = 0, done_cyc = -1;
        bit         rv_seen = 0, stalled = 0, finished = 0;
        logic [7:0] held = '0;
        wvalid = 1'b0;
        rready = 1'b1;
        start  = 1'b1;
        @(posedge config_clock); #1;
        start = 1'b0;
        while (!finished && cyc < BOUND) begin
            if (chain_enable) en++;
            if (done) begin
                dn++;
                done_cyc = cyc;
                if (busy) busy_bad++;
                finished = 1;
            end
            // Write side: gaps are counted only while the loader is asking for a word.
            if (wready && wi < int'(NW)) begin
                if (gap_left > 0) begin
                    gap_left--;
                    wvalid = 1'b0;
                    if (chain_enable) gap_en++;
                end else begin
                    wvalid   = 1'b1;
                    wdata    = v.w[wi];
                    wi++;
                    gap_left = int'(v.gap);
                end
            end else begin
                wvalid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                wdata  = 8'($urandom);
            end
            // Read side.
            if (rvalid) begin
                if (!rv_seen) begin
                    rv_seen   = 1;
                    hold_left = int'(v.hold);
                end
                if (stalled && rdata !== held) unstable++;
                if (hold_left > 0) begin
                    hold_left--;
                    rready = 1'b0;
                    if (chain_enable) hold_en++;
                end else begin
                    rready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (rready) begin
                    if (ri < int'(NW))
                        check($sformatf("%s rdata[%0d]", name, ri), 32'(rdata), 32'(v.exp_r[ri]));
                    ri++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = rdata;
                end
            end else begin
                stalled = 0;
                rready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start = (v.spam && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!finished) begin
                @(posedge config_clock); #1;
                cyc++;
            end
        end
        start  = 1'b0;
        wvalid = 1'b0;
        rready = 1'b1;
        check({name, " completed"}, 32'(finished), 32'd1);
        @(posedge config_clock); #1;
        if (done) dn++;
        check({name, " busy after"},      32'(busy),     32'd0);
        check({name, " done pulses"},     32'(dn),       32'd1);
        check({name, " shift count"},     32'(en),       32'(CL));
        check({name, " words written"},   32'(wi),       32'(NW));
        check({name, " words read"},      32'(ri),       32'(NW));
        check({name, " shift in gap"},    32'(gap_en),   32'd0);
        check({name, " shift in stall"},  32'(hold_en),  32'd0);
        check({name, " rdata unstable"},  32'(unstable), 32'd0);
        check({name, " busy with done"},  32'(busy_bad), 32'd0);
        if (v.exp_cyc != 8'd0)
            check({name, " frame cycles"}, 32'(done_cyc), 32'(v.exp_cyc));
    endtask

    task automatic reset_mid_frame();
        int en = 0, cyc = 0, dn = 0, wi = 0;
        rready = 1'b1;
        start  = 1'b1;
        @(posedge config_clock); #1;
        start = 1'b0;
        while (en < 13 && cyc < BOUND) begin
            if (chain_enable) en++;
            if (wready && wi < int'(NW)) begin
                wvalid = 1'b1;
                wdata  = 8'($urandom);
                wi++;
            end else begin
                wvalid = 1'b0;
            end
            @(posedge config_clock); #1;
            cyc++;
        end
        wvalid = 1'b0;
        check("mid-frame shifts reached", 32'(en), 32'd13);
        check("mid-frame busy before reset", 32'(busy), 32'd1);
        config_nreset = 1'b0;
        #1;
        check_idle_outputs("async reset");
        repeat (3) begin
            @(posedge config_clock); #1;
            if (done) dn++;
        end
        config_nreset = 1'b1;
        repeat (5) begin
            @(posedge config_clock); #1;
            if (done) dn++;
        end
        check("no done after abandoned frame", 32'(dn), 32'd0);
        check_idle_outputs("after mid-frame reset");
        model_prev = '0;
    endtask

    initial begin
        vec_t rv;
        config_nreset = 1'b0;
        start         = 1'b0;
        wvalid        = 1'b0;
        wdata         = '0;
        rready        = 1'b1;
        model_prev    = '0;

        // Directed frames: words listed last-to-first in the concatenations.
        vecs[0] = '{w: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, exp_r: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    gap: 8'd0, hold: 8'd0, spam: 1'b0, rnd: 1'b0, exp_cyc: 8'd42};
        vecs[1] = '{w: {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0}, exp_r: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
                    gap: 8'd0, hold: 8'd20, spam: 1'b0, rnd: 1'b0, exp_cyc: 8'd0};
        vecs[2] = '{w: {8'hFF, 8'h13, 8'h12, 8'h11, 8'h10}, exp_r: {8'h04, 8'hA3, 8'hA2, 8'hA1, 8'hA0},
                    gap: 8'd0, hold: 8'd0, spam: 1'b0, rnd: 1'b0, exp_cyc: 8'd42};
        vecs[3] = '{w: {8'h96, 8'hA5, 8'h3C, 8'hC3, 8'h5A}, exp_r: {8'h0F, 8'h13, 8'h12, 8'h11, 8'h10},
                    gap: 8'd3, hold: 8'd0, spam: 1'b0, rnd: 1'b0, exp_cyc: 8'd0};
        vecs[4] = '{w: {8'h0F, 8'hFF, 8'h00, 8'hFF, 8'h00}, exp_r: {8'h06, 8'hA5, 8'h3C, 8'hC3, 8'h5A},
                    gap: 8'd0, hold: 8'd0, spam: 1'b1, rnd: 1'b0, exp_cyc: 8'd0};
        vecs[5] = '{w: {8'h15, 8'h14, 8'h13, 8'h12, 8'h11}, exp_r: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    gap: 8'd0, hold: 8'd0, spam: 1'b0, rnd: 1'b0, exp_cyc: 8'd42};

        repeat (3) @(posedge config_clock);
        #1;
        check_idle_outputs("in reset");
        config_nreset = 1'b1;
        @(posedge config_clock); #1;
        check_idle_outputs("after reset");

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            model_update(vecs[i].w);
        end

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < int'(NW); i++) rv.w[i] = 8'($urandom);
            rv.exp_r   = model_prev;
            rv.gap     = 8'($urandom_range(0, 2));
            rv.hold    = 8'($urandom_range(0, 4));
            rv.spam    = 1'b1;
            rv.rnd     = 1'b1;
            rv.exp_cyc = 8'd0;
            run_frame(rv, $sformatf("rand%0d", f));
            model_update(rv.w);
        end

        reset_mid_frame();
        run_frame(vecs[5], "vec5");
        model_update(vecs[5].w);

        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < int'(NW); i++) rv.w[i] = 8'($urandom);
            rv.exp_r   = model_prev;
            rv.gap     = 8'($urandom_range(0, 3));
            rv.hold    = 8'($urandom_range(0, 6));
            rv.spam    = 1'b1;
            rv.rnd     = 1'b1;
            rv.exp_cyc = 8'd0;
            run_frame(rv, $sformatf("post-reset rand%0d", f));
            model_update(rv.w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
